mult_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one instance of the team's combinational `multiplier` (parallelism, ARCH_TYPE) among NUM_REQ requesters.
- Each requester uses a valid/ready operand channel.
- Accepted operands are registered, given one full cycle to settle through the multiplier, and the product is returned on a single valid/ready result channel tagged with the requester id.
- Sits between the issuing units and the multiplier datapath.

---
 rtl/mult_share_pkg.sv | 38 +++
 rtl/multiplier.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mult_share_ctrl.sv | 113 +++++++++++
 tb/tb_mult_share_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and the round-robin pick function for the multiplier-sharing controller.
// Sized for the largest supported requester count (16).
package mult_share_pkg;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // Circular search from ptr over the first n requesters; the first set valid bit wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int                  n);
    pick_t r;
    int    k;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !r.found && valid[k[MAX_ID_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[MAX_ID_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned multiplier; ARCH_TYPE 1 builds a shift-add partial-product
// array, any other value uses the direct operator.
module multiplier #(
  parameter int parallelism = 8,
  parameter int ARCH_TYPE   = 1
) (
  input  logic [parallelism-1:0]   a,
  input  logic [parallelism-1:0]   b,
  output logic [2*parallelism-1:0] product
);

  if (ARCH_TYPE == 1) begin : g_shift_add
    always_comb begin
      product = '0;
      for (int i = 0; i < parallelism; i++) begin
        if (b[i]) product = product + ({{parallelism{1'b0}}, a} << i);
      end
    end
  end else begin : g_direct
    assign product = {{parallelism{1'b0}}, a} * {{parallelism{1'b0}}, b};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
// Produces a one-hot grant, its index and a found flag.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  pick_t                pick;
  logic [MAX_REQ-1:0]   valid_ext;
  logic [MAX_ID_W-1:0]  ptr_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    ptr_ext                  = '0;
    ptr_ext[ID_W-1:0]        = ptr;
    pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    found                    = pick.found;
    idx                      = pick.idx[ID_W-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = pick.found && (pick.idx == MAX_ID_W'(i));
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier among NUM_REQ requesters: round-robin accept,
// one settle cycle in MUL, then a tagged result held on a valid/ready channel.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int parallelism = 8,
  parameter int ARCH_TYPE   = 1,
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*parallelism-1:0] req_a,
  input  logic [NUM_REQ*parallelism-1:0] req_b,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [ID_W-1:0]                res_id,
  output logic [2*parallelism-1:0]       res_product,
  output logic                           busy
);

  state_t                   state, state_next;
  logic [ID_W-1:0]          ptr, op_id, grant_idx;
  logic [parallelism-1:0]   op_a, op_b;
  logic [2*parallelism-1:0] mul_product;
  logic [NUM_REQ-1:0]       grant;
  logic                     found, accept;
  logic [parallelism-1:0]   a_arr [NUM_REQ];
  logic [parallelism-1:0]   b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*parallelism +: parallelism];
    assign b_arr[i] = req_b[i*parallelism +: parallelism];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (found)
  );

  multiplier #(
    .parallelism (parallelism),
    .ARCH_TYPE   (ARCH_TYPE)
  ) u_mult (
    .a       (op_a),
    .b       (op_b),
    .product (mul_product)
  );

  // Accept is gated by rst_n so req_ready stays low for the whole reset interval.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept     = 1'b1;
          state_next = MUL;
        end
      end
      MUL: state_next = RESP;
      RESP: begin
        if (res_ready) begin
          if (found) begin
            accept     = 1'b1;
            state_next = MUL;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) accept = 1'b0;
    req_ready = accept ? grant : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      res_product <= '0;
      res_id      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a  <= a_arr[grant_idx];
        op_b  <= b_arr[grant_idx];
        op_id <= grant_idx;
        ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == MUL) begin
        res_product <= mul_product;
        res_id      <= op_id;
      end
    end
  end

  assign res_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: table-driven single multiplies plus hand-written
// round-robin, backpressure, wrap-around and mid-operation reset sequences.
module tb_mult_share_ctrl;

  localparam int P = 8;
  localparam int N = 4;
  localparam int W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*P-1:0]   req_a;
  logic [N*P-1:0]   req_b;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_id;
  logic [2*P-1:0]   res_product;
  logic             busy;

  int tests_run;
  int tests_failed;

  typedef struct {
    int           idx;
    logic [P-1:0] a;
    logic [P-1:0] b;
    logic [2*P-1:0] prod;
  } vec_t;

  vec_t vecs [6];

  logic [P-1:0]   rr_a [N];
  logic [P-1:0]   rr_b [N];
  logic [2*P-1:0] rr_p [N];

  mult_share_ctrl #(
    .parallelism (P),
    .ARCH_TYPE   (1),
    .NUM_REQ     (N),
    .ID_W        (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_product (res_product),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_operands(input int idx, input logic [P-1:0] a, input logic [P-1:0] b);
    req_a[idx*P +: P] = a;
    req_b[idx*P +: P] = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // One isolated multiply from IDLE: grant, settle, result, handshake back to IDLE.
  task automatic applyStimulus(input vec_t v);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[v.idx] = 1'b1;
    res_ready = 1'b0;
    set_operands(v.idx, v.a, v.b);
    req_valid = onehot;
    #1;
    checkOutput("vec_grant", 32'(req_ready), 32'(onehot));
    checkOutput("vec_idle_busy", 32'(busy), 32'd0);
    step();
    req_valid = '0;
    checkOutput("vec_mul_res_valid", 32'(res_valid), 32'd0);
    checkOutput("vec_mul_busy", 32'(busy), 32'd1);
    checkOutput("vec_mul_ready", 32'(req_ready), 32'd0);
    step();
    checkOutput("vec_res_valid", 32'(res_valid), 32'd1);
    checkOutput("vec_res_id", 32'(res_id), 32'(v.idx));
    checkOutput("vec_res_product", 32'(res_product), 32'(v.prod));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checkOutput("vec_back_idle_valid", 32'(res_valid), 32'd0);
    checkOutput("vec_back_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{idx: 0, a: 8'h11, b: 8'h11, prod: 16'h0121};
    vecs[1] = '{idx: 1, a: 8'hFF, b: 8'hFF, prod: 16'hFE01};
    vecs[2] = '{idx: 2, a: 8'h00, b: 8'hA5, prod: 16'h0000};
    vecs[3] = '{idx: 3, a: 8'h80, b: 8'h02, prod: 16'h0100};
    vecs[4] = '{idx: 0, a: 8'h01, b: 8'hFF, prod: 16'h00FF};
    vecs[5] = '{idx: 2, a: 8'h0F, b: 8'h10, prod: 16'h00F0};

    rr_a[0] = 8'h03; rr_b[0] = 8'h05; rr_p[0] = 16'h000F;
    rr_a[1] = 8'h17; rr_b[1] = 8'h0B; rr_p[1] = 16'h00FD;
    rr_a[2] = 8'hC8; rr_b[2] = 8'h64; rr_p[2] = 16'h4E20;
    rr_a[3] = 8'hFF; rr_b[3] = 8'h02; rr_p[3] = 16'h01FE;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;

    // Reset values, with a request pending to prove req_ready stays low in reset.
    #2;
    req_valid = 4'b0001;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_product", 32'(res_product), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Round robin from a fresh reset: all valid, consumer always ready.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_operands(i, rr_a[i], rr_b[i]);
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp_grant;
      exp_grant = '0;
      exp_grant[k % N] = 1'b1;
      #1;
      checkOutput("rr_grant", 32'(req_ready), 32'(exp_grant));
      if (k > 0) begin
        checkOutput("rr_res_valid", 32'(res_valid), 32'd1);
        checkOutput("rr_res_id", 32'((k - 1) % N), 32'(res_id));
        checkOutput("rr_res_product", 32'(res_product), 32'(rr_p[(k - 1) % N]));
      end
      step();
      checkOutput("rr_mul_ready", 32'(req_ready), 32'd0);
      checkOutput("rr_mul_res_valid", 32'(res_valid), 32'd0);
      step();
    end

    // Backpressure: result of requester 0 held while requester 2 waits.
    req_valid = 4'b0100;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
      checkOutput("bp_res_id", 32'(res_id), 32'd0);
      checkOutput("bp_res_product", 32'(res_product), 32'(rr_p[0]));
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    checkOutput("bp_release_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    step();
    checkOutput("bp_new_res_valid", 32'(res_valid), 32'd1);
    checkOutput("bp_new_res_id", 32'(res_id), 32'd2);
    checkOutput("bp_new_res_product", 32'(res_product), 32'(rr_p[2]));

    // Wrap-around: grant 3, then with 1 and 3 valid the pointer has wrapped to 0.
    req_valid = 4'b1000;
    #1;
    checkOutput("wrap_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = 4'b1010;
    step();
    checkOutput("wrap_res_id3", 32'(res_id), 32'd3);
    checkOutput("wrap_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    checkOutput("wrap_res_id1", 32'(res_id), 32'd1);
    checkOutput("wrap_res_product1", 32'(res_product), 32'(rr_p[1]));
    step();
    checkOutput("wrap_idle_busy", 32'(busy), 32'd0);

    // Reset while in MUL: outputs drop immediately, no stale result, pointer back to 0.
    req_valid = 4'b0100;
    #1;
    checkOutput("mr_grant2", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    checkOutput("mr_in_mul_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_res_valid", 32'(res_valid), 32'd0);
    checkOutput("mr_req_ready", 32'(req_ready), 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("mr_no_stale_valid", 32'(res_valid), 32'd0);
      checkOutput("mr_no_stale_busy", 32'(busy), 32'd0);
    end
    req_valid = 4'b1010;
    #1;
    checkOutput("mr_first_grant", 32'(req_ready), 32'b0010);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
